ps2_mouse_init_seq: RTL and testbench

Host-side command sequencer that brings a PS/2 mouse from power-up to streaming mode. It drives the PS/2 transmitter's byte-write handshake and consumes bytes from the PS/2 receiver. It checks every response, retries on resend or timeout, and then forwards movement packets. It sits between the top-level mouse logic and the PS/2 Tx/Rx pair, and it is the only writer to the transmitter.

---
 rtl/ps2_mouse_init_seq.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ps2_mouse_init_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_init_seq.sv
// rtl/ps2_mouse_init_seq.sv - PS/2 mouse power-up command sequencer and stream forwarder
module ps2_mouse_init_seq #(
    parameter logic [7:0] SAMPLE_RATE = 8'd100,
    parameter int         ACK_TIMEOUT = 1_000_000,
    parameter int         BAT_TIMEOUT = 25_000_000,
    parameter int         MAX_RETRY   = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       TxWrite,
    output logic [7:0] TxData,
    input  logic       TxDone,
    input  logic       TxIdle,
    input  logic [7:0] RxData,
    input  logic       RxValid,
    output logic       Busy,
    output logic       Ready,
    output logic       Error,
    output logic [2:0] ErrCode,
    output logic [7:0] StreamData,
    output logic       StreamValid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_ACK,
        S_WAIT_BAT,
        S_WAIT_ID,
        S_READY,
        S_FAIL
    } state_t;

    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_RATE    = 8'hF3;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;
    localparam logic [7:0] RSP_ERROR   = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_RSP_TO  = 3'd1;
    localparam logic [2:0] ERR_BAT     = 3'd2;
    localparam logic [2:0] ERR_RETRY   = 3'd3;
    localparam logic [2:0] ERR_TX_TO   = 3'd4;

    // Timeout fires on the last cycle of the window, so compare against limit-1.
    localparam logic [25:0] ACK_LIM    = 26'(ACK_TIMEOUT - 1);
    localparam logic [25:0] BAT_LIM    = 26'(BAT_TIMEOUT - 1);
    localparam logic [7:0]  RETRY_LIM  = 8'(MAX_RETRY);

    state_t      r_state;
    logic [1:0]  r_index;
    logic [7:0]  r_retry;
    logic [25:0] r_timer;
    logic        r_tx_write;
    logic [7:0]  r_tx_data;
    logic        r_busy;
    logic        r_ready;
    logic        r_error;
    logic [2:0]  r_err_code;
    logic [7:0]  r_stream_data;
    logic        r_stream_valid;

    state_t      w_state_nxt;
    logic [1:0]  w_index_nxt;
    logic [7:0]  w_retry_nxt;
    logic        w_tx_write_nxt;
    logic [7:0]  w_tx_data_nxt;
    logic [2:0]  w_err_code_nxt;
    logic [7:0]  w_stream_data_nxt;
    logic        w_stream_valid_nxt;
    logic [7:0]  w_script_byte;
    logic        w_ack_to;
    logic        w_bat_to;
    logic        w_can_retry;

    assign TxWrite     = r_tx_write;
    assign TxData      = r_tx_data;
    assign Busy        = r_busy;
    assign Ready       = r_ready;
    assign Error       = r_error;
    assign ErrCode     = r_err_code;
    assign StreamData  = r_stream_data;
    assign StreamValid = r_stream_valid;

    assign w_ack_to    = (r_timer == ACK_LIM);
    assign w_bat_to    = (r_timer == BAT_LIM);
    assign w_can_retry = (r_retry < RETRY_LIM);

    // Command script lookup for the current index.
    always_comb begin
        w_script_byte = CMD_RESET;
        case (r_index)
            2'd0:    w_script_byte = CMD_RESET;
            2'd1:    w_script_byte = CMD_RATE;
            2'd2:    w_script_byte = SAMPLE_RATE;
            default: w_script_byte = CMD_ENABLE;
        endcase
    end

    // Next-state and next-output decode; every path starts from hold values.
    always_comb begin
        w_state_nxt        = r_state;
        w_index_nxt        = r_index;
        w_retry_nxt        = r_retry;
        w_tx_write_nxt     = 1'b0;
        w_tx_data_nxt      = r_tx_data;
        w_err_code_nxt     = r_err_code;
        w_stream_data_nxt  = r_stream_data;
        w_stream_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_FAIL: begin
                if (Start) begin
                    w_state_nxt    = S_SEND;
                    w_index_nxt    = 2'd0;
                    w_retry_nxt    = 8'd0;
                    w_err_code_nxt = ERR_NONE;
                end
            end

            S_SEND: begin
                if (TxIdle) begin
                    w_tx_write_nxt = 1'b1;
                    w_tx_data_nxt  = w_script_byte;
                    w_state_nxt    = S_WAIT_TX;
                end
            end

            S_WAIT_TX: begin
                if (TxDone) begin
                    w_state_nxt = S_WAIT_ACK;
                end else if (w_ack_to) begin
                    w_state_nxt    = S_FAIL;
                    w_err_code_nxt = ERR_TX_TO;
                end
            end

            S_WAIT_ACK: begin
                if (RxValid && RxData == RSP_ACK) begin
                    if (r_index == 2'd0) begin
                        w_state_nxt = S_WAIT_BAT;
                    end else if (r_index == 2'd3) begin
                        w_state_nxt = S_READY;
                        w_retry_nxt = 8'd0;
                    end else begin
                        w_state_nxt = S_SEND;
                        w_index_nxt = r_index + 2'd1;
                        w_retry_nxt = 8'd0;
                    end
                end else if (RxValid && RxData == RSP_RESEND) begin
                    if (w_can_retry) begin
                        w_retry_nxt = r_retry + 8'd1;
                        w_state_nxt = S_SEND;
                    end else begin
                        w_state_nxt    = S_FAIL;
                        w_err_code_nxt = ERR_RETRY;
                    end
                end else if (RxValid && RxData == RSP_ERROR) begin
                    w_state_nxt    = S_FAIL;
                    w_err_code_nxt = ERR_BAT;
                end else if (w_ack_to) begin
                    // Unrecognised bytes do not hold off the response timer.
                    if (w_can_retry) begin
                        w_retry_nxt = r_retry + 8'd1;
                        w_state_nxt = S_SEND;
                    end else begin
                        w_state_nxt    = S_FAIL;
                        w_err_code_nxt = ERR_RSP_TO;
                    end
                end
            end

            S_WAIT_BAT: begin
                if (RxValid && RxData == RSP_BAT_OK) begin
                    w_state_nxt = S_WAIT_ID;
                end else if (RxValid && RxData == RSP_ERROR) begin
                    w_state_nxt    = S_FAIL;
                    w_err_code_nxt = ERR_BAT;
                end else if (w_bat_to) begin
                    w_state_nxt    = S_FAIL;
                    w_err_code_nxt = ERR_RSP_TO;
                end
            end

            S_WAIT_ID: begin
                // The device ID is accepted whatever its value.
                if (RxValid) begin
                    w_state_nxt = S_SEND;
                    w_index_nxt = 2'd1;
                    w_retry_nxt = 8'd0;
                end else if (w_bat_to) begin
                    w_state_nxt    = S_FAIL;
                    w_err_code_nxt = ERR_RSP_TO;
                end
            end

            S_READY: begin
                // A restart takes priority over forwarding a coincident byte.
                if (Start) begin
                    w_state_nxt    = S_SEND;
                    w_index_nxt    = 2'd0;
                    w_retry_nxt    = 8'd0;
                    w_err_code_nxt = ERR_NONE;
                end else if (RxValid) begin
                    w_stream_valid_nxt = 1'b1;
                    w_stream_data_nxt  = RxData;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, sequencing registers and shared timeout timer.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_index <= 2'd0;
            r_retry <= 8'd0;
            r_timer <= 26'd0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_retry <= w_retry_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= 26'd0;
            end else if (r_timer != '1) begin
                r_timer <= r_timer + 26'd1;
            end
        end
    end

    // Registered outputs; status flags follow the state being entered.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tx_write     <= 1'b0;
            r_tx_data      <= 8'd0;
            r_busy         <= 1'b0;
            r_ready        <= 1'b0;
            r_error        <= 1'b0;
            r_err_code     <= ERR_NONE;
            r_stream_data  <= 8'd0;
            r_stream_valid <= 1'b0;
        end else begin
            r_tx_write     <= w_tx_write_nxt;
            r_tx_data      <= w_tx_data_nxt;
            r_busy         <= (w_state_nxt == S_SEND)     ||
                              (w_state_nxt == S_WAIT_TX)  ||
                              (w_state_nxt == S_WAIT_ACK) ||
                              (w_state_nxt == S_WAIT_BAT) ||
                              (w_state_nxt == S_WAIT_ID);
            r_ready        <= (w_state_nxt == S_READY);
            r_error        <= (w_state_nxt == S_FAIL);
            r_err_code     <= w_err_code_nxt;
            r_stream_data  <= w_stream_data_nxt;
            r_stream_valid <= w_stream_valid_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// tb/tb_ps2_mouse_init_seq.sv - directed self-checking bench for ps2_mouse_init_seq
module tb_ps2_mouse_init_seq;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       TxWrite;
    logic [7:0] TxData;
    logic       TxDone;
    logic       TxIdle;
    logic [7:0] RxData;
    logic       RxValid;
    logic       Busy;
    logic       Ready;
    logic       Error;
    logic [2:0] ErrCode;
    logic [7:0] StreamData;
    logic       StreamValid;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int st_cnt   = 0;
    int base;

    ps2_mouse_init_seq #(
        .SAMPLE_RATE (8'h64),
        .ACK_TIMEOUT (16),
        .BAT_TIMEOUT (40),
        .MAX_RETRY   (3)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .TxWrite     (TxWrite),
        .TxData      (TxData),
        .TxDone      (TxDone),
        .TxIdle      (TxIdle),
        .RxData      (RxData),
        .RxValid     (RxValid),
        .Busy        (Busy),
        .Ready       (Ready),
        .Error       (Error),
        .ErrCode     (ErrCode),
        .StreamData  (StreamData),
        .StreamValid (StreamValid)
    );

    // 10 ns clock.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count transmitter writes and forwarded bytes on the inactive edge.
    always @(negedge Clk) begin
        if (TxWrite) wr_cnt = wr_cnt + 1;
        if (StreamValid) st_cnt = st_cnt + 1;
    end

    // Hard stop if the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=stall expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b);
        RxData  = b;
        RxValid = 1'b1;
        tick();
        RxValid = 1'b0;
    endtask

    // Wait for a write strobe, check its byte, then acknowledge with TxDone.
    task automatic send_byte(input string tag, input logic [7:0] exp, input logic give_done);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (TxWrite) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_seen"}, {31'd0, got}, 32'd1);
        check({tag, "_data"}, {24'd0, TxData}, {24'd0, exp});
        if (give_done) begin
            TxDone = 1'b1;
            tick();
            TxDone = 1'b0;
        end
    endtask

    initial begin
        Reset   = 1'b1;
        Start   = 1'b0;
        TxDone  = 1'b0;
        TxIdle  = 1'b1;
        RxData  = 8'h00;
        RxValid = 1'b0;
        ticks(3);
        check("rst_txwrite", {31'd0, TxWrite}, 32'd0);
        check("rst_txdata",  {24'd0, TxData}, 32'd0);
        check("rst_busy",    {31'd0, Busy}, 32'd0);
        check("rst_ready",   {31'd0, Ready}, 32'd0);
        check("rst_error",   {31'd0, Error}, 32'd0);
        check("rst_errcode", {29'd0, ErrCode}, 32'd0);
        check("rst_svalid",  {31'd0, StreamValid}, 32'd0);
        Reset = 1'b0;
        ticks(2);

        // Nominal init, with an ignored Start during WAIT_BAT and a stray byte.
        base = wr_cnt;
        pulse_start();
        check("start_busy", {31'd0, Busy}, 32'd1);
        check("start_nowrite_yet", {31'd0, TxWrite}, 32'd0);
        tick();
        check("start_to_write", {31'd0, TxWrite}, 32'd1);
        send_byte("nom_ff", 8'hFF, 1'b1);
        rx(8'hFA);
        pulse_start();
        rx(8'hAA);
        rx(8'h00);
        send_byte("nom_f3", 8'hF3, 1'b1);
        rx(8'h33);
        check("stray_not_fwd", {31'd0, StreamValid}, 32'd0);
        rx(8'hFA);
        send_byte("nom_rate", 8'h64, 1'b1);
        rx(8'hFA);
        send_byte("nom_f4", 8'hF4, 1'b1);
        check("txdata_held", {24'd0, TxData}, 32'hF4);
        rx(8'hFA);
        check("nom_ready", {31'd0, Ready}, 32'd1);
        check("nom_busy",  {31'd0, Busy}, 32'd0);
        check("nom_errcode", {29'd0, ErrCode}, 32'd0);
        check("nom_writes", wr_cnt - base, 32'd4);
        check("nom_no_stream", st_cnt, 32'd0);

        // Streaming: one-cycle latency, single-cycle pulse, same data.
        base = st_cnt;
        rx(8'h08);
        check("st1_valid", {31'd0, StreamValid}, 32'd1);
        check("st1_data",  {24'd0, StreamData}, 32'h08);
        tick();
        check("st1_pulse", {31'd0, StreamValid}, 32'd0);
        rx(8'h05);
        check("st2_valid", {31'd0, StreamValid}, 32'd1);
        check("st2_data",  {24'd0, StreamData}, 32'h05);
        rx(8'hFD);
        check("st3_valid", {31'd0, StreamValid}, 32'd1);
        check("st3_data",  {24'd0, StreamData}, 32'hFD);
        tick();
        check("st_count", st_cnt - base, 32'd3);

        // Restart in READY coinciding with a byte; then resend F3 once.
        base = wr_cnt;
        Start   = 1'b1;
        RxData  = 8'h55;
        RxValid = 1'b1;
        tick();
        Start   = 1'b0;
        RxValid = 1'b0;
        check("rst_in_ready_nostream", {31'd0, StreamValid}, 32'd0);
        check("rst_in_ready_busy", {31'd0, Busy}, 32'd1);
        check("rst_in_ready_ready", {31'd0, Ready}, 32'd0);
        send_byte("rs_ff", 8'hFF, 1'b1);
        rx(8'hFA);
        rx(8'hAA);
        rx(8'h00);
        send_byte("rs_f3a", 8'hF3, 1'b1);
        rx(8'hFE);
        send_byte("rs_f3b", 8'hF3, 1'b1);
        rx(8'hFA);
        send_byte("rs_rate", 8'h64, 1'b1);
        rx(8'hFA);
        send_byte("rs_f4", 8'hF4, 1'b1);
        rx(8'hFA);
        check("rs_ready", {31'd0, Ready}, 32'd1);
        check("rs_writes", wr_cnt - base, 32'd5);

        // Retries exhausted on F4.
        base = wr_cnt;
        pulse_start();
        send_byte("rx_ff", 8'hFF, 1'b1);
        rx(8'hFA);
        rx(8'hAA);
        rx(8'h00);
        send_byte("rx_f3", 8'hF3, 1'b1);
        rx(8'hFA);
        send_byte("rx_rate", 8'h64, 1'b1);
        rx(8'hFA);
        for (int i = 0; i < 4; i++) begin
            check("rx_not_failed_yet", {31'd0, Error}, 32'd0);
            send_byte("rx_f4", 8'hF4, 1'b1);
            rx(8'hFE);
        end
        check("retry_error", {31'd0, Error}, 32'd1);
        check("retry_code",  {29'd0, ErrCode}, 32'd3);
        ticks(5);
        check("retry_writes", wr_cnt - base, 32'd7);
        check("retry_code_held", {29'd0, ErrCode}, 32'd3);

        // Start in FAIL clears the error; BAT failure follows.
        base = wr_cnt;
        pulse_start();
        check("fail_restart_err", {31'd0, Error}, 32'd0);
        check("fail_restart_code", {29'd0, ErrCode}, 32'd0);
        send_byte("bat_ff", 8'hFF, 1'b1);
        rx(8'hFA);
        rx(8'hFC);
        check("bat_error", {31'd0, Error}, 32'd1);
        check("bat_code",  {29'd0, ErrCode}, 32'd2);
        ticks(20);
        check("bat_no_more_writes", wr_cnt - base, 32'd1);

        // Transmitter never finishes: FAIL exactly 16 edges after the write.
        pulse_start();
        send_byte("txto_ff", 8'hFF, 1'b0);
        ticks(15);
        check("txto_not_yet", {31'd0, Error}, 32'd0);
        tick();
        check("txto_error", {31'd0, Error}, 32'd1);
        check("txto_code",  {29'd0, ErrCode}, 32'd4);

        // Transmitter finishes but the mouse stays silent.
        base = wr_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte("rspto_ff", 8'hFF, 1'b1);
        ticks(20);
        check("rspto_error", {31'd0, Error}, 32'd1);
        check("rspto_code",  {29'd0, ErrCode}, 32'd1);
        check("rspto_writes", wr_cnt - base, 32'd4);

        // Transmitter busy holds SEND; reset during WAIT_TX clears at once.
        base = wr_cnt;
        TxIdle = 1'b0;
        pulse_start();
        ticks(10);
        check("hold_no_write", wr_cnt - base, 32'd0);
        check("hold_busy", {31'd0, Busy}, 32'd1);
        TxIdle = 1'b1;
        send_byte("hold_ff", 8'hFF, 1'b0);
        Reset = 1'b1;
        #1;
        check("async_txwrite", {31'd0, TxWrite}, 32'd0);
        check("async_busy",    {31'd0, Busy}, 32'd0);
        check("async_txdata",  {24'd0, TxData}, 32'd0);
        check("async_errcode", {29'd0, ErrCode}, 32'd0);
        tick();
        Reset = 1'b0;
        ticks(5);
        check("post_reset_idle_busy", {31'd0, Busy}, 32'd0);
        check("post_reset_no_write", {31'd0, TxWrite}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
